bcd_to_binary_seq: RTL and testbench

//   Sequential packed-BCD to binary converter, inverse of convert_to_bcd.

---
 rtl/bcd_to_binary_seq.sv | 112 +++++++++++
 tb/tb_bcd_to_binary_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Packed-BCD to binary, folding one digit per clock MSD first (acc = acc*10 + d).
// start at edge E gives a one-cycle done after edge E+DIGITS; start is ignored while busy.
module bcd_to_binary_seq #(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*DIGITS-1:0]    bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic [BIN_WIDTH-1:0]   bin_out,
  output logic                   error
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [4*DIGITS-1:0]    shift_q, shift_d;
  logic [BIN_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_acc_q, err_acc_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic                   error_q, error_d;

  logic [3:0]             digit;
  logic [BIN_WIDTH-1:0]   acc_next;
  logic                   err_next;

  // The current MS nibble folded into the running total; *10 as shift-add.
  always_comb begin
    digit    = shift_q[4*DIGITS-1 -: 4];
    acc_next = (acc_q << 3) + (acc_q << 1) + BIN_WIDTH'(digit);
    err_next = err_acc_q | (digit > 4'd9);
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    bin_d     = bin_q;
    error_d   = error_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE shares IDLE's accept path so back-to-back operands cost DIGITS+1 cycles.
        if (start) begin
          shift_d   = bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          err_acc_d = 1'b0;
          state_d   = CONVERT;
        end else begin
          state_d   = IDLE;
        end
      end

      CONVERT: begin
        acc_d     = acc_next;
        err_acc_d = err_next;
        shift_d   = shift_q << 4;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
          bin_d   = err_next ? '0 : acc_next;
          error_d = err_next;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      bin_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      bin_q     <= bin_d;
      error_q   <= error_d;
    end
  end

  assign busy    = (state_q == CONVERT);
  assign done    = (state_q == DONE);
  assign bin_out = bin_q;
  assign error   = error_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed and exhaustive checks for bcd_to_binary_seq (DIGITS=4, BIN_WIDTH=16).
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [15:0] bin_out;
  logic        error;

  int pass_cnt;
  int total_cnt;

  bcd_to_binary_seq #(.DIGITS(4), .BIN_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = rising edges after the start edge until done is visible (expect 4).
  task automatic run_conv(input logic [15:0] v, output logic [15:0] b,
                          output logic e, output int lat);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    b = bin_out;
    e = error;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, error} !== 3'b000 || bin_out !== 16'd0)
      $display("FAIL reset: busy=%b done=%b error=%b bin_out=%0d, need all 0", busy, done, error, bin_out);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] b; logic e; int lat;
    @(negedge clk);
    start = 1'b1; bcd_in = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL busy_after_start: busy=%b done=%b, need 1/0", busy, done);
    else pass_cnt++;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    b = bin_out; e = error;
    total_cnt++;
    if (lat !== 4) $display("FAIL latency_1234: got %0d edges, need 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (b !== 16'd1234 || e !== 1'b0 || busy !== 1'b0)
      $display("FAIL conv_1234: bin=%0d err=%b busy=%b, need 1234/0/0", b, e, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL done_one_cycle: done=%b on following cycle, need 0", done);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    logic [15:0] b; logic e; int lat;
    run_conv(16'h9999, b, e, lat);
    total_cnt++;
    if (b !== 16'h270F || e !== 1'b0 || lat !== 4)
      $display("FAIL conv_9999: bin=%h err=%b lat=%0d, need 270f/0/4", b, e, lat);
    else pass_cnt++;
    run_conv(16'h0000, b, e, lat);
    total_cnt++;
    if (b !== 16'd0 || e !== 1'b0 || lat !== 4)
      $display("FAIL conv_0000: bin=%0d err=%b lat=%0d, need 0/0/4", b, e, lat);
    else pass_cnt++;
  endtask

  task automatic test_invalid();
    logic [15:0] b; logic e; int lat;
    run_conv(16'h12A4, b, e, lat);
    total_cnt++;
    if (b !== 16'd0 || e !== 1'b1 || lat !== 4)
      $display("FAIL conv_12A4: bin=%0d err=%b lat=%0d, need 0/1/4", b, e, lat);
    else pass_cnt++;
    run_conv(16'h0042, b, e, lat);
    total_cnt++;
    if (b !== 16'd42 || e !== 1'b0)
      $display("FAIL conv_0042: bin=%0d err=%b, need 42/0", b, e);
    else pass_cnt++;
    run_conv(16'hF000, b, e, lat);
    total_cnt++;
    if (b !== 16'd0 || e !== 1'b1)
      $display("FAIL conv_F000: bin=%0d err=%b, need 0/1", b, e);
    else pass_cnt++;
    run_conv(16'h000B, b, e, lat);
    total_cnt++;
    if (b !== 16'd0 || e !== 1'b1)
      $display("FAIL conv_000B: bin=%0d err=%b, need 0/1", b, e);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int lat; int extra_done; int hold_bad;
    @(negedge clk);
    start = 1'b1; bcd_in = 16'h0500;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    @(negedge clk);
    lat = 1;
    start = 1'b1; bcd_in = 16'h0777;
    @(negedge clk);
    lat = 2;
    start = 1'b0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    total_cnt++;
    if (lat !== 4 || bin_out !== 16'd500 || error !== 1'b0)
      $display("FAIL ignore_start: bin=%0d err=%b lat=%0d, need 500/0/4", bin_out, error, lat);
    else pass_cnt++;
    extra_done = 0; hold_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (bin_out !== 16'd500) hold_bad++;
    end
    total_cnt++;
    if (extra_done !== 0 || hold_bad !== 0)
      $display("FAIL hold_500: extra_done=%0d bad_hold_cycles=%0d, need 0/0", extra_done, hold_bad);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [19:0] done_v; logic [19:0] busy_v;
    @(negedge clk);
    start = 1'b1; bcd_in = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      done_v[i] = done;
      busy_v[i] = busy;
    end
    start = 1'b0;
    total_cnt++;
    if (done_v !== 20'b10000_10000_10000_10000)
      $display("FAIL b2b_done_pattern: got %b, need %b", done_v, 20'b10000_10000_10000_10000);
    else pass_cnt++;
    total_cnt++;
    if (busy_v !== 20'b01111_01111_01111_01111)
      $display("FAIL b2b_busy_pattern: got %b, need %b", busy_v, 20'b01111_01111_01111_01111);
    else pass_cnt++;
    total_cnt++;
    if (bin_out !== 16'd1 || error !== 1'b0)
      $display("FAIL b2b_result: bin=%0d err=%b, need 1/0", bin_out, error);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [15:0] b; logic e; int lat; int seen_done;
    // Leave a nonzero error/bin_out behind so the reset clearing is visible.
    run_conv(16'h00C1, b, e, lat);
    run_conv(16'h0321, b, e, lat);
    @(negedge clk);
    start = 1'b1; bcd_in = 16'h8765;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, error} !== 3'b000 || bin_out !== 16'd0)
      $display("FAIL reset_abort: busy=%b done=%b err=%b bin=%0d, need all 0", busy, done, error, bin_out);
    else pass_cnt++;
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    total_cnt++;
    if (seen_done !== 0)
      $display("FAIL reset_no_done: %0d cycles with done/busy after abort, need 0", seen_done);
    else pass_cnt++;
    run_conv(16'h0010, b, e, lat);
    total_cnt++;
    if (b !== 16'd10 || e !== 1'b0 || lat !== 4)
      $display("FAIL after_reset_0010: bin=%0d err=%b lat=%0d, need 10/0/4", b, e, lat);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    logic [15:0] v; logic [15:0] b; logic e; int lat; int bad; int first_bad;
    bad = 0; first_bad = -1;
    for (int n = 0; n < 10000; n++) begin
      v = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
      run_conv(v, b, e, lat);
      if (b !== 16'(n) || e !== 1'b0 || lat !== 4) begin
        if (first_bad < 0) first_bad = n;
        bad++;
      end
    end
    total_cnt++;
    if (bad !== 0)
      $display("FAIL exhaustive: %0d wrong results (first at %0d), need 0", bad, first_bad);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
